mem_port_arbiter: RTL

Shares the single unified instruction/data memory port of the 5-stage RV32I core between the IF stage (instruction fetch) and the MEM stage (loads/stores). It sits between the pipeline and the memory inside `top`. It arbitrates requests and tracks the one outstanding transaction. It routes each response back to the requester that issued it and drives the pipeline stall signals while a requester waits.

---
 rtl/rv_mem_pkg.sv | 19 +
 rtl/arb_wait_ctr.sv | 33 +++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and default widths for the unified memory port arbiter.
package rv_mem_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } arb_state_e;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_e;

endpackage

// File: rtl/arb_wait_ctr.sv
// arb_wait_ctr: saturating count of cycles a fetch has been refused.
// Present only when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_wait_ctr #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = clr ? '0 : (inc && cnt_q != CW'(MAX)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one access outstanding.
// Define ARB_STARVE_GUARD_EN to let a fetch refused MAX_WAIT cycles win over data.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       st_we_q;
    logic       st_we_d;
    logic       starve;
    logic       sel_d;
    logic       accept;
    req_id_e    win;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;

    arb_wait_ctr #(
        .MAX (MAX_WAIT),
        .CW  (CW)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req & ~i_gnt),
        .clr   (i_gnt),
        .cnt   (wait_cnt)
    );

    assign starve = i_req && (wait_cnt == CW'(MAX_WAIT));
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign starve = 1'b0;
`endif

    assign win    = (d_req && !starve) ? REQ_D : REQ_I;
    assign sel_d  = (win == REQ_D);
    assign accept = (state_q == IDLE) && (i_req || d_req) && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            st_we_q <= st_we_d;
        end
    end

    // st_we remembers a store so its acknowledge returns no data
    always_comb begin
        state_d = state_q;
        st_we_d = st_we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sel_d ? WAIT_D : WAIT_I;
                    st_we_d = sel_d && d_we;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rst_n gating keeps every output at 0 while reset is held, whatever the inputs
    always_comb begin
        mem_req   = rst_n && (state_q == IDLE) && (i_req || d_req);
        mem_we    = mem_req && sel_d && d_we;
        mem_addr  = !mem_req ? '0 : sel_d ? d_addr : i_addr;
        mem_wdata = (mem_req && sel_d) ? d_wdata : '0;
        mem_be    = (mem_req && sel_d) ? d_be : '0;
        i_gnt     = mem_req && mem_ready && !sel_d;
        d_gnt     = mem_req && mem_ready && sel_d;
        i_rvalid  = rst_n && (state_q == WAIT_I) && mem_rvalid;
        d_rvalid  = rst_n && (state_q == WAIT_D) && mem_rvalid;
        i_rdata   = i_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !st_we_q) ? mem_rdata : '0;
        stall_if  = rst_n && i_req && !i_rvalid;
        stall_mem = rst_n && (d_req || state_q == WAIT_D) && !d_rvalid;
    end

endmodule
